// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit.
// Holds the FSM state encoding, the slice-count limit, and a helper function
// that sizes the slice index counter.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_NCHUNK = 64;

    // Width of the slice index counter. It is at least one bit, so that the
    // single-slice case still has a legal register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_seq_rca.sv
// rca_chunk: combinational CHUNK-bit ripple-carry adder built from full adders.
// Ports:
//   a, b   in  CHUNK  addend slices
//   cin    in  1      carry into bit 0
//   sum    out CHUNK  slice sum
//   cout   out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (used for signed overflow)
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
        assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign cout  = carry[CHUNK];
    assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: multi-cycle WIDTH-bit add/subtract unit that processes
// one CHUNK-bit slice per clock through a single shared ripple adder.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (accepted only while idle)
//   a, b, cin, sub         operands; sub=1 computes a-b-cin
//   out_valid / out_ready  result handshake (result held until accepted)
//   sum, cout, ovf         result, carry out (sub: 1 = no borrow), signed overflow
module chunked_adder_seq
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1 || NCHUNK > MAX_NCHUNK) begin : g_bad_params
        $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK with 1..64 slices");
    end

    state_t           state_q,  state_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    // Slice views of the latched operands, selected by idx_q for the shared adder.
    logic [CHUNK-1:0] a_slices [NCHUNK];
    logic [CHUNK-1:0] b_slices [NCHUNK];

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slices
        assign a_slices[gi] = a_q[gi*CHUNK +: CHUNK];
        assign b_slices[gi] = b_q[gi*CHUNK +: CHUNK];
    end

    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_c_msb;

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .a     (a_slices[idx_q]),
        .b     (b_slices[idx_q]),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = slice_cout;
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = slice_sum;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // Only the final slice holds the word MSB, so only it defines cout/ovf.
                    cout_d  = slice_cout;
                    ovf_d   = slice_c_msb ^ slice_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
